// File: rtl/timer_multi_ch_if.sv
// Avalon-MM slave bus bundle for timer_multi_ch: 3-bit register index plus channel select,
// 16-bit data, active-low write strobe.
interface timer_multi_ch_if #(
  parameter int NUM_CH = 4
);
  localparam int AW = 3 + $clog2(NUM_CH);

  // Writes take effect when chipselect=1 and write_n=0 at a rising clk edge. Reads need
  // no strobe: readdata always shows the register addressed in the previous cycle.
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/timer_multi_ch.sv
// NUM_CH independent down-counting interval timers behind an Avalon-MM slave, combined irq.
// Optional macro TIMER_CASCADE_EN: control bit4 (casc) chains channel n to channel n-1 reloads.
module timer_multi_ch #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 49
) (
  input  logic            clk,
  input  logic            reset_n,
  timer_multi_ch_if.slave bus,
  output logic            irq
);
  localparam int AW = 3 + $clog2(NUM_CH);
  localparam int HW = CNT_W - 16;
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

`ifdef TIMER_CASCADE_EN
  localparam bit CASC_EN = 1'b1;
`else
  localparam bit CASC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD_L = 3'd2,
    REG_PERIOD_H = 3'd3,
    REG_SNAP_L   = 3'd4,
    REG_SNAP_H   = 3'd5,
    REG_PRESCALE = 3'd6,
    REG_IRQ_PEND = 3'd7
  } reg_e;

  // Per-channel state
  logic [CNT_W-1:0] counter  [NUM_CH];
  logic [CNT_W-1:0] period   [NUM_CH];
  logic [CNT_W-1:0] snapshot [NUM_CH];
  logic [15:0]      prescale [NUM_CH];
  logic [15:0]      pcount   [NUM_CH];
  logic [NUM_CH-1:0] ito, cont, start_rb, stop_rb, casc;
  logic [NUM_CH-1:0] running, timeout, force_reload;

  // Decoded bus strobes and per-cycle events
  logic [NUM_CH-1:0] wr_status, wr_ctrl, wr_per_l, wr_per_h, wr_snap, wr_pre;
  logic [NUM_CH-1:0] start_go, stop_go, tick, reload_ev;
  logic [3:0]        ch_sel;
  logic              ch_ok;
  logic              wr_en;
  reg_e              reg_idx;
  logic [15:0]       irq_pend;
  logic [15:0]       rd_mux;
  logic [15:0]       rd_q;

  generate
    if (AW > 3) begin : g_sel
      assign ch_sel = 4'(bus.address[AW-1:3]);
    end else begin : g_nosel
      assign ch_sel = 4'd0;
    end
  endgenerate

  assign reg_idx = reg_e'(bus.address[2:0]);
  assign ch_ok   = (int'(ch_sel) < NUM_CH);
  assign wr_en   = bus.chipselect & ~bus.write_n & ch_ok;

  always_comb begin
    wr_status = '0;
    wr_ctrl   = '0;
    wr_per_l  = '0;
    wr_per_h  = '0;
    wr_snap   = '0;
    wr_pre    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && int'(ch_sel) == c) begin
        case (reg_idx)
          REG_STATUS:             wr_status[c] = 1'b1;
          REG_CONTROL:            wr_ctrl[c]   = 1'b1;
          REG_PERIOD_L:           wr_per_l[c]  = 1'b1;
          REG_PERIOD_H:           wr_per_h[c]  = 1'b1;
          REG_SNAP_L, REG_SNAP_H: wr_snap[c]   = 1'b1;
          REG_PRESCALE:           wr_pre[c]    = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign start_go = wr_ctrl & {NUM_CH{bus.writedata[2]}};
  assign stop_go  = wr_ctrl & {NUM_CH{bus.writedata[3]}};

  // A cascaded channel ticks in the same cycle its lower neighbour reloads, so the
  // chain is evaluated in channel order within one cycle.
  always_comb begin
    logic prev_ev;
    prev_ev   = 1'b0;
    tick      = '0;
    reload_ev = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick[c]      = running[c] & (casc[c] ? prev_ev : (pcount[c] == prescale[c]));
      reload_ev[c] = tick[c] & (counter[c] == '0);
      prev_ev      = reload_ev[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        counter[c]  <= RST_PERIOD;
        period[c]   <= RST_PERIOD;
        snapshot[c] <= '0;
        prescale[c] <= '0;
        pcount[c]   <= '0;
      end
      ito          <= '0;
      cont         <= '0;
      start_rb     <= '0;
      stop_rb      <= '0;
      casc         <= '0;
      running      <= '0;
      timeout      <= '0;
      force_reload <= '0;
      rd_q         <= '0;
    end else begin
      rd_q         <= rd_mux;
      force_reload <= wr_per_l | wr_per_h;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ctrl[c]) begin
          ito[c]      <= bus.writedata[0];
          cont[c]     <= bus.writedata[1];
          start_rb[c] <= bus.writedata[2];
          stop_rb[c]  <= bus.writedata[3];
          casc[c]     <= CASC_EN && (c != 0) && bus.writedata[4];
        end
        if (wr_per_l[c]) period[c][15:0]       <= bus.writedata;
        if (wr_per_h[c]) period[c][CNT_W-1:16] <= bus.writedata[HW-1:0];
        if (wr_pre[c])   prescale[c]           <= bus.writedata;
        // Captures the register value, i.e. the count before any decrement this cycle.
        if (wr_snap[c])  snapshot[c]           <= counter[c];

        // A pending period reload overrides start, ticks and the prescaler.
        if (force_reload[c]) begin
          counter[c] <= period[c];
          pcount[c]  <= '0;
          running[c] <= 1'b0;
        end else begin
          if (tick[c]) begin
            counter[c] <= (counter[c] == '0) ? period[c] : counter[c] - CNT_W'(1);
          end
          if (start_go[c]) begin
            pcount[c] <= '0;
          end else if (running[c]) begin
            pcount[c] <= (pcount[c] == prescale[c]) ? 16'd0 : pcount[c] + 16'd1;
          end
          if (stop_go[c]) begin
            running[c] <= 1'b0;
          end else if (start_go[c]) begin
            running[c] <= 1'b1;
          end else if (reload_ev[c] && !cont[c]) begin
            running[c] <= 1'b0;
          end
        end

        if (reload_ev[c] && !force_reload[c]) begin
          timeout[c] <= 1'b1;
        end else if (wr_status[c]) begin
          timeout[c] <= 1'b0;
        end
      end
    end
  end

  assign irq_pend = 16'(timeout & ito);

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ok && int'(ch_sel) == c) begin
        case (reg_idx)
          REG_STATUS:   rd_mux = {14'd0, running[c], timeout[c]};
          REG_CONTROL:  rd_mux = {11'd0, casc[c], stop_rb[c], start_rb[c], cont[c], ito[c]};
          REG_PERIOD_L: rd_mux = period[c][15:0];
          REG_PERIOD_H: rd_mux = 16'(period[c][CNT_W-1:16]);
          REG_SNAP_L:   rd_mux = snapshot[c][15:0];
          REG_SNAP_H:   rd_mux = 16'(snapshot[c][CNT_W-1:16]);
          REG_PRESCALE: rd_mux = prescale[c];
          REG_IRQ_PEND: rd_mux = irq_pend;
          default:      rd_mux = '0;
        endcase
      end
    end
  end

  assign bus.readdata = rd_q;
  assign irq          = |(timeout & ito);

endmodule

// File: tb/tb_timer_multi_ch.sv
// Self-checking bench for timer_multi_ch: register table, hand-timed corner sequences and
// randomized single-channel runs against an interval model (period+1)*(prescale+1).
module tb_timer_multi_ch;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 24;
  localparam int LIMIT  = 300;

`ifdef TIMER_CASCADE_EN
  localparam logic [15:0] CASC_RB = 16'h0010;
`else
  localparam logic [15:0] CASC_RB = 16'h0000;
`endif

  typedef struct {
    logic        do_wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[$];

  timer_multi_ch_if #(.NUM_CH(NUM_CH)) bus ();

  timer_multi_ch #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_PERIOD(49)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .irq(irq)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: timeout interval in clk cycles for a free-running channel.
  function automatic int model_interval(int p, int s);
    return (p + 1) * (s + 1);
  endfunction

  function automatic logic [5:0] a(int c, int idx);
    return 6'(c * 8 + idx);
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: each is entered and left at a falling edge and spans one clk cycle.
  task automatic wr(logic [5:0] addr, logic [15:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(logic [5:0] addr, output logic [15:0] data);
    bus.address = addr;
    @(negedge clk);
    data = bus.readdata;
  endtask

  task automatic rd_check(string name, logic [5:0] addr, logic [15:0] exp);
    logic [15:0] d;
    rd(addr, d);
    check(name, d, exp);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (irq !== 1'b1 && n <= LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, c, p, s, ival;
    bit cm;
    logic [15:0] d;

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset_n        = 1'b0;
    idle(2);
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_readdata", bus.readdata, 16'h0);
    reset_n = 1'b1;
    idle(1);

    // Register table
    vecs.push_back('{1'b0, a(0, 2), 16'h0000, 16'h0031});
    vecs.push_back('{1'b0, a(0, 0), 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, a(0, 3), 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, a(0, 1), 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, a(3, 6), 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, a(0, 4), 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, a(3, 6), 16'hBEEF, 16'hBEEF});
    vecs.push_back('{1'b1, a(3, 3), 16'hFFFF, 16'h00FF});
    vecs.push_back('{1'b1, a(3, 2), 16'h1234, 16'h1234});
    vecs.push_back('{1'b1, a(3, 1), 16'h0003, 16'h0003});
    vecs.push_back('{1'b1, a(3, 1), 16'h000C, 16'h000C});
    vecs.push_back('{1'b0, a(3, 0), 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, a(5, 6), 16'h0055, 16'h0000});
    vecs.push_back('{1'b0, a(7, 7), 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, a(1, 1), 16'h0010, CASC_RB});
    vecs.push_back('{1'b1, a(0, 1), 16'h0010, 16'h0000});
    vecs.push_back('{1'b0, a(2, 7), 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, a(4, 5), 16'h0000, 16'h0000});
    foreach (vecs[i]) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    check("table_irq", 16'(irq), 16'h0);

    // ch1 continuous, period 9, prescale 0
    do_reset();
    wr(a(1, 2), 16'd9);
    wr(a(1, 6), 16'd0);
    wr(a(1, 1), 16'h0007);
    wait_irq(n);
    check("ch1_first_timeout", 16'(n), 16'd10);
    wr(a(1, 0), 16'h0000);
    check("ch1_irq_clear", 16'(irq), 16'h0);
    wait_irq(n);
    check("ch1_period_timeout", 16'(n + 1), 16'd10);
    rd_check("ch1_irq_pending", a(0, 7), 16'h0002);
    wr(a(1, 0), 16'h0000);
    check("ch1_irq_clear2", 16'(irq), 16'h0);
    idle(7);
    wr(a(1, 0), 16'h0000);   // lands on the edge where timeout sets again
    check("ch1_set_beats_clear", 16'(irq), 16'h1);
    rd_check("ch1_status_set", a(1, 0), 16'h0003);
    wr(a(1, 1), 16'h0008);
    wr(a(1, 0), 16'h0000);

    // ch2 one-shot, period 3, prescale 4
    do_reset();
    wr(a(2, 2), 16'd3);
    wr(a(2, 6), 16'd4);
    wr(a(2, 1), 16'h0005);
    wait_irq(n);
    check("ch2_oneshot_timeout", 16'(n), 16'd20);
    rd_check("ch2_status_stopped", a(2, 0), 16'h0001);
    wr(a(2, 4), 16'h0000);
    rd_check("ch2_reloaded", a(2, 4), 16'd3);
    wr(a(2, 0), 16'h0000);
    idle(25);
    check("ch2_no_retrigger", 16'(irq), 16'h0);
    rd_check("ch2_status_idle", a(2, 0), 16'h0000);

    // ch0 snapshot during decrement, then period write while running
    wr(a(0, 1), 16'h0006);
    wr(a(0, 4), 16'h0000);
    rd_check("ch0_snap_pre_dec", a(0, 4), 16'h0031);
    idle(3);
    rd_check("ch0_running", a(0, 0), 16'h0002);
    wr(a(0, 2), 16'd7);
    rd_check("ch0_running_1cyc", a(0, 0), 16'h0002);
    rd_check("ch0_stopped_2cyc", a(0, 0), 16'h0000);
    wr(a(0, 5), 16'h0000);
    rd_check("ch0_snap_new_period", a(0, 4), 16'd7);
    rd_check("ch0_snap_h", a(0, 5), 16'd0);

`ifdef TIMER_CASCADE_EN
    do_reset();
    wr(a(1, 2), 16'd2);
    wr(a(0, 2), 16'd4);
    wr(a(1, 1), 16'h0017);
    wr(a(0, 1), 16'h0006);
    wait_irq(n);
    check("casc_first", 16'(n), 16'd15);
    wr(a(1, 0), 16'h0000);
    wait_irq(n);
    check("casc_period", 16'(n + 1), 16'd15);
    rd_check("casc_ctrl_rb", a(1, 1), 16'h0017);
`endif

    // Randomized single-channel runs against the interval model
    do_reset();
    for (int t = 0; t < 10; t++) begin
      c    = $urandom_range(NUM_CH - 1, 0);
      p    = $urandom_range(12, 2);
      s    = $urandom_range(3, 0);
      cm   = 1'($urandom_range(1, 0));
      ival = model_interval(p, s);
      wr(a(c, 2), 16'(p));
      wr(a(c, 6), 16'(s));
      wr(a(c, 1), cm ? 16'h0007 : 16'h0005);
      exp_q.push_back(16'(ival));
      wait_irq(n);
      check($sformatf("rnd%0d_first", t), 16'(n), exp_q.pop_front());
      exp_q.push_back(16'(1 << c));
      rd(a($urandom_range(NUM_CH - 1, 0), 7), d);
      check($sformatf("rnd%0d_pending", t), d, exp_q.pop_front());
      if (cm) begin
        wr(a(c, 0), 16'h0000);
        exp_q.push_back(16'(ival - 2));
        wait_irq(n);
        check($sformatf("rnd%0d_second", t), 16'(n), exp_q.pop_front());
      end else begin
        rd_check($sformatf("rnd%0d_status", t), a(c, 0), 16'h0001);
        wr(a(c, 4), 16'h0000);
        rd_check($sformatf("rnd%0d_reload", t), a(c, 4), 16'(p));
        wr(a(c, 0), 16'h0000);
        idle(ival + 3);
        check($sformatf("rnd%0d_quiet", t), 16'(irq), 16'h0);
      end
      wr(a(c, 1), 16'h0008);
      wr(a(c, 0), 16'h0000);
      check($sformatf("rnd%0d_cleanup", t), 16'(irq), 16'h0);
    end

    // Reset asserted mid-count
    wr(a(4, 1), 16'h0007);
    wr(a(4, 2), 16'd60);
    idle(1);
    wr(a(4, 1), 16'h0007);
    idle(20);
    do_reset();
    check("midrst_irq", 16'(irq), 16'h0);
    rd_check("midrst_status", a(4, 0), 16'h0000);
    rd_check("midrst_ctrl", a(4, 1), 16'h0000);
    rd_check("midrst_period", a(4, 2), 16'h0031);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_multi_ch.md
Name: timer_multi_ch

Overview:
- Avalon-MM slave providing NUM_CH independent down-counting interval timers, each with a programmable prescaler.
- Each channel runs one-shot or continuous, with snapshot capture and per-channel interrupt enable.
- A single combined irq output goes to the processor interrupt controller.
- Drop-in successor to the single-channel interval timer in the system: channel 0 with prescale 0 keeps the same register offsets.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, counter/period width in bits (17..32).
- DEFAULT_PERIOD, 49, reset value of every channel's period and counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3+clog2(NUM_CH)  bits[2:0] register index, upper bits channel select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  OR of all channel interrupts.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (reset_n); all state is cleared asynchronously on reset_n low.
- Register map per channel:
  - 0 status: {running, timeout}. Any write clears timeout.
  - 1 control: bit0 ito, bit1 cont, bit2 start, bit3 stop. Bits[1:0] are stored; start/stop act as strobes and also read back as written.
  - 2 period_l.
  - 3 period_h: bits[CNT_W-17:0] valid, unused bits read 0.
  - 4 snap_l, 5 snap_h: a write to either captures the counter into the snapshot; reads return the snapshot.
  - 6 prescale: 16 bit.
  - 7 irq_pending: read-only, bit n = channel n timeout & ito. Same value at any channel's index 7.
- Channel select >= NUM_CH: reads return 0, writes ignored.
- Read latency is 1 cycle: readdata is registered from the address presented in the previous cycle. chipselect is not needed for reads.
- Reset values:
  - readdata = 0, irq = 0.
  - counter = period = DEFAULT_PERIOD, prescale = 0.
  - control = 0, running = 0, timeout = 0, snapshot = 0, prescaler count = 0.
- Prescaler: per-channel pcount counts 0..prescale while running. tick asserts when pcount == prescale, then pcount returns to 0. With prescale = 0, tick every cycle.
- Counter, on a running tick:
  - if counter == 0: reload from period and set timeout.
  - if cont = 0: running clears in the same cycle.
  - otherwise: counter decrements by 1.
- Period write: force_reload asserts the next cycle, which loads counter from period, clears pcount and clears running. Software must restart the channel.
- Start strobe sets running; pcount is cleared. If start and stop are in the same write, stop wins. If start coincides with force_reload, force_reload wins.
- Simultaneous events:
  - timeout set and status write clear in the same cycle: set wins.
  - snapshot write in the same cycle as a decrement: captures the pre-decrement value.
- Period of 0 with cont = 1: timeout every (prescale+1) cycles.
- irq = OR over channels of (timeout & ito). It is combinational from registers, with no added latency.
- Reset asserted mid-count: all channels stop immediately and return to reset values.

Optional Feature:
- Macro: TIMER_CASCADE_EN.
- Defined: control bit4 (casc) exists on channels 1..NUM_CH-1. When casc = 1, channel n ignores its own prescaler. Its tick becomes the cycle in which channel n-1 sets timeout (reload event), giving CNT_W*2 chained counts. casc reads back in control bit4. Channel 0 bit4 reads 0.
- Undefined: control bit4 is not stored and reads 0; all channels use their own prescaler only.

Test Plan:
- Reset, then read ch0 period_l/status -> 49 / 0x0000; irq = 0.
- ch1: period = 9, prescale = 0, control = 0x7 (start, cont, ito) -> timeout and irq first at the 10th tick after start, then every 10 cycles. Status write clears timeout; irq drops 1 cycle later.
- ch2: period = 3, prescale = 4, control = 0x5 (one-shot) -> timeout after 20 cycles; running = 0; counter reloaded to 3; no further timeout.
- Period write while ch0 running -> running = 0 two cycles after write; counter = new period; snapshot write then reads back the new period.
- Status-clear write in the same cycle as ch1 timeout -> timeout remains 1. Control write 0xC (start + stop) -> running stays 0.
- TIMER_CASCADE_EN: ch0 period = 4 cont, ch1 period = 2 casc + cont + ito -> ch1 timeout every 15 clk cycles. Without the macro, bit4 reads 0.
